// File: rtl/alu_sequencer.sv
// Multi-cycle control FSM for the 8-bit add/sub/neg/cmp datapath.
// Strobes are Moore outputs of the registered state. start is only honoured in IDLE.
module alu_sequencer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       alu_sequencer_clk,
  input  logic       alu_sequencer_rst,
  input  logic       alu_sequencer_start,
  input  logic [1:0] alu_sequencer_opcode,
  input  logic       alu_sequencer_carry_in,
  output logic       alu_sequencer_busy,
  output logic       alu_sequencer_done,
  output logic       alu_sequencer_reg2_load,
  output logic       alu_sequencer_reg1_load,
  output logic       alu_sequencer_complement_enable,
  output logic       alu_sequencer_mux1_sel,
  output logic       alu_sequencer_alu_enable,
  output logic       alu_sequencer_acc_load,
  output logic       alu_sequencer_flag_load,
  output logic       alu_sequencer_neg_carry
);

  // A setting of 0 behaves as 1, so the last COMPL count is 0 in both cases.
  localparam logic [3:0] SETTLE_LAST = (SETTLE_CYCLES <= 1) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH_A = 3'd1;
  localparam logic [2:0] S_FETCH_B = 3'd2;
  localparam logic [2:0] S_COMPL   = 3'd3;
  localparam logic [2:0] S_EXEC    = 3'd4;
  localparam logic [2:0] S_WB      = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_NEG = 2'b10;
  localparam logic [1:0] OP_CMP = 2'b11;

  logic [2:0] state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [3:0] cnt_q, cnt_d;
  logic       neg_carry_q, neg_carry_d;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    neg_carry_d = neg_carry_q;
    case (state_q)
      S_IDLE: begin
        if (alu_sequencer_start) begin
          op_d    = alu_sequencer_opcode;
          // NEG works on B alone, so the A fetch is skipped.
          state_d = (alu_sequencer_opcode == OP_NEG) ? S_FETCH_B : S_FETCH_A;
        end
      end
      S_FETCH_A: state_d = S_FETCH_B;
      S_FETCH_B: begin
        cnt_d   = 4'd0;
        state_d = (op_q == OP_ADD) ? S_EXEC : S_COMPL;
      end
      S_COMPL: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q >= SETTLE_LAST) begin
          state_d     = S_EXEC;
          neg_carry_d = alu_sequencer_carry_in;
        end
      end
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge alu_sequencer_clk) begin
    if (alu_sequencer_rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_ADD;
      cnt_q       <= 4'd0;
      neg_carry_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      neg_carry_q <= neg_carry_d;
    end
  end

  logic uses_compl;
  assign uses_compl = (op_q != OP_ADD);

  always_comb begin
    alu_sequencer_busy              = (state_q != S_IDLE);
    alu_sequencer_done              = 1'b0;
    alu_sequencer_reg2_load         = 1'b0;
    alu_sequencer_reg1_load         = 1'b0;
    alu_sequencer_complement_enable = 1'b0;
    alu_sequencer_mux1_sel          = 1'b0;
    alu_sequencer_alu_enable        = 1'b0;
    alu_sequencer_acc_load          = 1'b0;
    alu_sequencer_flag_load         = 1'b0;
    case (state_q)
      S_FETCH_A: alu_sequencer_reg2_load = 1'b1;
      S_FETCH_B: alu_sequencer_reg1_load = 1'b1;
      S_COMPL: begin
        alu_sequencer_complement_enable = 1'b1;
        alu_sequencer_mux1_sel          = 1'b1;
      end
      S_EXEC: begin
        alu_sequencer_alu_enable        = 1'b1;
        alu_sequencer_complement_enable = uses_compl;
        alu_sequencer_mux1_sel          = uses_compl;
      end
      S_WB: begin
        // CMP only updates flags; the accumulator keeps its value.
        alu_sequencer_flag_load         = 1'b1;
        alu_sequencer_acc_load          = (op_q != OP_CMP);
        alu_sequencer_complement_enable = uses_compl;
        alu_sequencer_mux1_sel          = uses_compl;
      end
      S_DONE:  alu_sequencer_done = 1'b1;
      default: ;
    endcase
  end

  assign alu_sequencer_neg_carry = neg_carry_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed scenarios then random traffic, checked each
// cycle against a per-operation schedule model.
module tb_alu_sequencer;

  localparam int S = 3;
  localparam int SEFF = (S < 1) ? 1 : S;

  localparam logic [8:0] B_BUSY = 9'h100;
  localparam logic [8:0] B_DONE = 9'h080;
  localparam logic [8:0] B_R2   = 9'h040;
  localparam logic [8:0] B_R1   = 9'h020;
  localparam logic [8:0] B_CE   = 9'h010;
  localparam logic [8:0] B_MUX  = 9'h008;
  localparam logic [8:0] B_ALU  = 9'h004;
  localparam logic [8:0] B_ACC  = 9'h002;
  localparam logic [8:0] B_FLAG = 9'h001;

  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] NEG = 2'b10;
  localparam logic [1:0] CMP = 2'b11;

  typedef struct packed {
    logic [8:0] o;
    logic       fin;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] opcode = 2'b00;
  logic       carry_in = 1'b0;
  logic busy, done, reg2_load, reg1_load, ce, mux, alu_en, acc_load, flag_load, neg_carry;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  ent_t sched[$];
  logic negc_exp = 1'b0;

  always #5 clk = ~clk;

  alu_sequencer #(.SETTLE_CYCLES(S)) dut (
    .alu_sequencer_clk              (clk),
    .alu_sequencer_rst              (rst),
    .alu_sequencer_start            (start),
    .alu_sequencer_opcode           (opcode),
    .alu_sequencer_carry_in         (carry_in),
    .alu_sequencer_busy             (busy),
    .alu_sequencer_done             (done),
    .alu_sequencer_reg2_load        (reg2_load),
    .alu_sequencer_reg1_load        (reg1_load),
    .alu_sequencer_complement_enable(ce),
    .alu_sequencer_mux1_sel         (mux),
    .alu_sequencer_alu_enable       (alu_en),
    .alu_sequencer_acc_load         (acc_load),
    .alu_sequencer_flag_load        (flag_load),
    .alu_sequencer_neg_carry        (neg_carry)
  );

  // Expected outputs for each cycle of an accepted operation, cycle 1 first.
  function automatic void build_sched(input logic [1:0] op);
    logic [8:0] cm;
    cm = (op == ADD) ? 9'h000 : (B_CE | B_MUX);
    if (op != NEG) sched.push_back('{B_BUSY | B_R2, 1'b0});
    sched.push_back('{B_BUSY | B_R1, 1'b0});
    if (op != ADD)
      for (int i = 0; i < SEFF; i++) sched.push_back('{B_BUSY | B_CE | B_MUX, (i == SEFF - 1)});
    sched.push_back('{B_BUSY | B_ALU | cm, 1'b0});
    sched.push_back('{B_BUSY | B_FLAG | ((op != CMP) ? B_ACC : 9'h000) | cm, 1'b0});
    sched.push_back('{B_BUSY | B_DONE, 1'b0});
  endfunction

  task automatic tick(input logic st, input logic [1:0] op, input logic rs, input logic cin);
    ent_t cur;
    logic [8:0] got, want;
    start = st; opcode = op; rst = rs; carry_in = cin;
    @(posedge clk);
    if (rs) begin
      sched.delete();
      negc_exp = 1'b0;
    end else if (sched.size() > 0) begin
      cur = sched.pop_front();
      if (cur.fin) negc_exp = cin;
    end else if (st) begin
      build_sched(op);
    end
    #1;
    cyc++;
    want = (sched.size() > 0) ? sched[0].o : 9'h000;
    got  = {busy, done, reg2_load, reg1_load, ce, mux, alu_en, acc_load, flag_load};
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL outputs cyc=%0d observed=%b expected=%b", cyc, got, want);
    end
    checks++;
    assert (neg_carry === negc_exp) else begin
      errors++;
      $error("FAIL neg_carry cyc=%0d observed=%b expected=%b", cyc, neg_carry, negc_exp);
    end
    checks++;
    assert (($countones({reg1_load, reg2_load, alu_en, acc_load}) <= 1) && (!ce || mux)) else begin
      errors++;
      $error("FAIL exclusivity cyc=%0d observed=%b expected=one-hot-or-zero with ce->mux", cyc, got);
    end
  endtask

  task automatic idle_ticks(input int n, input logic cin);
    for (int i = 0; i < n; i++) tick(1'b0, 2'b00, 1'b0, cin);
  endtask

  initial begin
    // reset, including a start that reset must override
    tick(1'b0, ADD, 1'b1, 1'b0);
    tick(1'b1, SUB, 1'b1, 1'b1);
    idle_ticks(1, 1'b0);

    // ADD
    tick(1'b1, ADD, 1'b0, 1'b1);
    idle_ticks(6, 1'b1);

    // SUB with carry high through COMPL
    tick(1'b1, SUB, 1'b0, 1'b1);
    idle_ticks(9, 1'b1);

    // NEG with carry low
    tick(1'b1, NEG, 1'b0, 1'b0);
    idle_ticks(8, 1'b0);

    // CMP with carry high, opcode wiggled after acceptance, then an ADD
    tick(1'b1, CMP, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) tick(1'b0, 2'(i), 1'b0, 1'b1);
    tick(1'b1, ADD, 1'b0, 1'b0);
    idle_ticks(6, 1'b0);

    // start while busy is ignored; start right after DONE is taken
    tick(1'b1, ADD, 1'b0, 1'b0);
    tick(1'b0, ADD, 1'b0, 1'b0);
    tick(1'b1, NEG, 1'b0, 1'b0);
    tick(1'b0, ADD, 1'b0, 1'b0);
    tick(1'b0, ADD, 1'b0, 1'b0);
    tick(1'b1, NEG, 1'b0, 1'b0);
    tick(1'b1, SUB, 1'b0, 1'b1);
    idle_ticks(9, 1'b1);

    // reset during the second COMPL cycle of a SUB
    tick(1'b1, SUB, 1'b0, 1'b1);
    idle_ticks(3, 1'b1);
    tick(1'b0, ADD, 1'b1, 1'b1);
    idle_ticks(3, 1'b1);
    tick(1'b1, ADD, 1'b1, 1'b0);
    idle_ticks(2, 1'b0);

    // random traffic
    for (int i = 0; i < 600; i++)
      tick(($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
